// File: rtl/blink_rate_detector.sv
// Blink-rate receiver: measures half-periods of a 50%-duty blink line and locks onto 1/10/50/100 Hz.
// Optional build macro PERIOD_OUT_EN adds o_meas_stb / o_half_period measurement outputs.
`timescale 1ns/1ps
module blink_rate_detector #(
   parameter int CNT_WIDTH    = 16,
   parameter int C_HP_100HZ   = 125,
   parameter int C_HP_50HZ    = 250,
   parameter int C_HP_10HZ    = 1250,
   parameter int C_HP_1HZ     = 12500,
   parameter int TOL_SHIFT    = 3,
   parameter int LOCK_COUNT   = 4,
   parameter int TIMEOUT_CLKS = 25000
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_blink,
`ifdef PERIOD_OUT_EN
   output logic                 o_meas_stb,
   output logic [CNT_WIDTH-1:0] o_half_period,
`endif
   output logic                 o_valid,
   output logic [1:0]           o_rate,
   output logic                 o_lost
);

   localparam int MC_W = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_WIDTH-1:0] L_HP_100 = CNT_WIDTH'(C_HP_100HZ);
   localparam logic [CNT_WIDTH-1:0] L_HP_50  = CNT_WIDTH'(C_HP_50HZ);
   localparam logic [CNT_WIDTH-1:0] L_HP_10  = CNT_WIDTH'(C_HP_10HZ);
   localparam logic [CNT_WIDTH-1:0] L_HP_1   = CNT_WIDTH'(C_HP_1HZ);
   localparam logic [CNT_WIDTH-1:0] L_CNT_MAX = CNT_WIDTH'(TIMEOUT_CLKS - 1);
   localparam logic [MC_W-1:0]      L_LOCK    = MC_W'(LOCK_COUNT);

   localparam logic [1:0] RATE_100HZ = 2'b00;
   localparam logic [1:0] RATE_50HZ  = 2'b01;
   localparam logic [1:0] RATE_10HZ  = 2'b10;
   localparam logic [1:0] RATE_1HZ   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEAS,
      S_LOCKED
   } state_t;

   // |hp - center| <= center >> TOL_SHIFT, evaluated in signed arithmetic
   function automatic logic f_in_window(input logic [CNT_WIDTH-1:0] hp,
                                        input logic [CNT_WIDTH-1:0] center);
      logic signed [CNT_WIDTH+1:0] diff;
      logic signed [CNT_WIDTH+1:0] tol;
      diff = $signed({2'b00, hp}) - $signed({2'b00, center});
      if (diff < 0) diff = -diff;
      tol = $signed({2'b00, (center >> TOL_SHIFT)});
      return (diff <= tol);
   endfunction

   logic                 r_blink_p0;
   logic                 r_blink_p1;
   logic                 r_blink_p2;
   logic                 w_edge;

   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_hp;
   logic                 w_timeout;

   logic                 w_match;
   logic [1:0]           w_class;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [MC_W-1:0]      r_match_cnt;
   logic [MC_W-1:0]      w_match_cnt_nxt;
   logic [1:0]           r_last_class;
   logic [1:0]           w_last_class_nxt;
   logic                 r_valid;
   logic                 w_valid_nxt;
   logic [1:0]           r_rate;
   logic [1:0]           w_rate_nxt;
   logic                 r_lost;
   logic                 w_lost_nxt;

   // Stage p0/p1: metastability synchronizer; p2: delayed copy for edge detect
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_blink_p0 <= 1'b0;
         r_blink_p1 <= 1'b0;
         r_blink_p2 <= 1'b0;
      end else begin
         r_blink_p0 <= i_blink;
         r_blink_p1 <= r_blink_p0;
         r_blink_p2 <= r_blink_p1;
      end
   end

   assign w_edge = r_blink_p1 ^ r_blink_p2;

   // Half-period counter: restarts on every edge, parks at the timeout value
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_cnt <= '0;
      end else if (w_edge) begin
         r_cnt <= '0;
      end else if (r_cnt != L_CNT_MAX) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign w_hp      = r_cnt + CNT_WIDTH'(1);
   assign w_timeout = (r_cnt == L_CNT_MAX) && !w_edge;

   always_comb begin
      w_match = 1'b1;
      w_class = RATE_100HZ;
      if (f_in_window(w_hp, L_HP_100)) begin
         w_class = RATE_100HZ;
      end else if (f_in_window(w_hp, L_HP_50)) begin
         w_class = RATE_50HZ;
      end else if (f_in_window(w_hp, L_HP_10)) begin
         w_class = RATE_10HZ;
      end else if (f_in_window(w_hp, L_HP_1)) begin
         w_class = RATE_1HZ;
      end else begin
         w_match = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_match_cnt_nxt  = r_match_cnt;
      w_last_class_nxt = r_last_class;
      w_valid_nxt      = r_valid;
      w_rate_nxt       = r_rate;
      w_lost_nxt       = r_lost;

      if (w_edge) begin
         w_lost_nxt = 1'b0;
         if (r_state == S_IDLE) begin
            w_state_nxt     = S_MEAS;
            w_match_cnt_nxt = '0;
         end else if ((r_state == S_LOCKED) && w_match && (w_class == r_rate)) begin
            w_state_nxt = S_LOCKED;
         end else begin
            // Leaving LOCKED still counts this measurement toward a new lock
            w_state_nxt = S_MEAS;
            w_valid_nxt = 1'b0;
            if (!w_match) begin
               w_match_cnt_nxt = '0;
            end else begin
               if (w_class == r_last_class) begin
                  w_match_cnt_nxt = r_match_cnt + MC_W'(1);
               end else begin
                  w_last_class_nxt = w_class;
                  w_match_cnt_nxt  = MC_W'(1);
               end
               if ((r_state == S_MEAS) && (w_match_cnt_nxt >= L_LOCK)) begin
                  w_state_nxt = S_LOCKED;
                  w_valid_nxt = 1'b1;
                  w_rate_nxt  = w_class;
               end
            end
         end
      end else if (w_timeout) begin
         w_state_nxt = S_IDLE;
         w_valid_nxt = 1'b0;
         w_lost_nxt  = 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state      <= S_IDLE;
         r_match_cnt  <= '0;
         r_last_class <= 2'b00;
         r_valid      <= 1'b0;
         r_rate       <= 2'b00;
         r_lost       <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_match_cnt  <= w_match_cnt_nxt;
         r_last_class <= w_last_class_nxt;
         r_valid      <= w_valid_nxt;
         r_rate       <= w_rate_nxt;
         r_lost       <= w_lost_nxt;
      end
   end

   assign o_valid = r_valid;
   assign o_rate  = r_rate;
   assign o_lost  = r_lost;

`ifdef PERIOD_OUT_EN
   logic                 w_meas;
   logic                 r_meas_stb;
   logic [CNT_WIDTH-1:0] r_half_period;

   // The IDLE first edge has no valid preceding edge, so it is not a measurement
   assign w_meas = w_edge && (r_state != S_IDLE);

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_meas_stb    <= 1'b0;
         r_half_period <= '0;
      end else begin
         r_meas_stb <= w_meas;
         if (w_meas) begin
            r_half_period <= w_hp;
         end
      end
   end

   assign o_meas_stb    = r_meas_stb;
   assign o_half_period = r_half_period;
`endif

endmodule

// File: tb/tb_blink_rate_detector.sv
// Scoreboard bench for blink_rate_detector; expectations queued as each blink edge is driven.
// Define PERIOD_OUT_EN for both files to exercise the measurement outputs.
`timescale 1ns/1ps
module tb_blink_rate_detector;
   localparam int CNT_WIDTH = 16;
   localparam int CLK_HALF  = 5;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 blink = 1'b0;
   logic                 o_valid;
   logic [1:0]           o_rate;
   logic                 o_lost;
`ifdef PERIOD_OUT_EN
   logic                 o_meas_stb;
   logic [CNT_WIDTH-1:0] o_half_period;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_last   = 0;

   typedef struct {
      string      name;
      logic       valid;
      logic [1:0] rate;
      logic       lost;
   } exp_t;

   exp_t sb[$];

   always #CLK_HALF clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   blink_rate_detector dut (
      .i_clock       (clk),
      .i_reset_n     (rst_n),
      .i_blink       (blink),
`ifdef PERIOD_OUT_EN
      .o_meas_stb    (o_meas_stb),
      .o_half_period (o_half_period),
`endif
      .o_valid       (o_valid),
      .o_rate        (o_rate),
      .o_lost        (o_lost)
   );

   // Toggle i_blink exactly gap clocks after the previous toggle, then return at the
   // falling edge following the clock on which the DUT registers that edge.
   task automatic edge_after(input int gap);
      while (cyc < t_last + gap) begin
         @(posedge clk);
         #1;
      end
      blink  = ~blink;
      t_last = cyc;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0;
      blink = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sb.push_back('{"reset_state", 1'b0, 2'b00, 1'b1});
      e = sb.pop_front();
      n_checks++;
      if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
         n_fail++;
         $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                  e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
      end
`ifdef PERIOD_OUT_EN
      n_checks++;
      if ({o_meas_stb, o_half_period} !== {1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_period: got stb=%b hp=%0d, want stb=0 hp=0", o_meas_stb, o_half_period);
      end
`endif
      rst_n = 1'b1;
      sb.push_back('{"idle_no_edge", 1'b0, 2'b00, 1'b1});
      repeat (20) @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
         n_fail++;
         $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                  e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
      end
   endtask

   task automatic test_lock_100hz();
      exp_t e;
      for (int i = 1; i <= 5; i++) begin
         sb.push_back('{$sformatf("lock100_edge%0d", i), (i == 5), 2'b00, 1'b0});
         edge_after(125);
         e = sb.pop_front();
         n_checks++;
         if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                     e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
         end
      end
   endtask

   task automatic test_switch_1hz();
      exp_t e;
      for (int i = 1; i <= 4; i++) begin
         sb.push_back('{$sformatf("switch1hz_edge%0d", i), (i == 4),
                        (i == 4) ? 2'b11 : 2'b00, 1'b0});
         edge_after(12500);
         e = sb.pop_front();
         n_checks++;
         if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                     e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
         end
      end
   endtask

   task automatic test_timeout_10hz();
      exp_t e;
      for (int i = 1; i <= 4; i++) begin
         sb.push_back('{$sformatf("lock10_edge%0d", i), (i == 4),
                        (i == 4) ? 2'b10 : 2'b11, 1'b0});
         edge_after(1250);
         e = sb.pop_front();
         n_checks++;
         if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                     e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
         end
      end
      // Line held: still locked one clock before the timeout, lost exactly at it
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{(i == 0) ? "timeout_minus1" : "timeout_exact",
                        (i == 0), 2'b10, (i == 1)});
         if (i == 0) repeat (24999) @(posedge clk);
         else        @(posedge clk);
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                     e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
         end
      end
      sb.push_back('{"resume_edge", 1'b0, 2'b10, 1'b0});
      edge_after(140);
      e = sb.pop_front();
      n_checks++;
      if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
         n_fail++;
         $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                  e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
      end
   endtask

   task automatic test_tolerance_edge();
      exp_t e;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 4)
            sb.push_back('{$sformatf("tol140_edge%0d", i), (i == 4),
                           (i == 4) ? 2'b00 : 2'b10, 1'b0});
         else
            sb.push_back('{$sformatf("tol141_edge%0d", i - 4), 1'b0, 2'b00, 1'b0});
         edge_after((i <= 4) ? 140 : 141);
         e = sb.pop_front();
         n_checks++;
         if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                     e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
         end
      end
   endtask

   task automatic test_reset_midop();
      exp_t e;
      for (int i = 1; i <= 4; i++) begin
         sb.push_back('{$sformatf("lock50_edge%0d", i), (i == 4),
                        (i == 4) ? 2'b01 : 2'b00, 1'b0});
         edge_after(250);
         e = sb.pop_front();
         n_checks++;
         if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                     e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
         end
      end
      // Leave the line low so the cleared synchronizer does not see a phantom edge
      if (blink) edge_after(250);
      sb.push_back('{"midop_reset", 1'b0, 2'b00, 1'b1});
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
         n_fail++;
         $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                  e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
      end
      for (int i = 1; i <= 5; i++) begin
         sb.push_back('{$sformatf("relock50_edge%0d", i), (i == 5),
                        (i == 5) ? 2'b01 : 2'b00, 1'b0});
         edge_after(250);
         e = sb.pop_front();
         n_checks++;
         if ({o_valid, o_rate, o_lost} !== {e.valid, e.rate, e.lost}) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b l=%b, want v=%b r=%b l=%b",
                     e.name, o_valid, o_rate, o_lost, e.valid, e.rate, e.lost);
         end
      end
   endtask

`ifdef PERIOD_OUT_EN
   task automatic test_period_out();
      logic [CNT_WIDTH:0] hp_q[$];
      logic [CNT_WIDTH:0] hx;
      if (blink) edge_after(250);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         hp_q.push_back((i == 1) ? {1'b0, 16'd0} : {1'b1, 16'd250});
         edge_after(250);
         hx = hp_q.pop_front();
         n_checks++;
         if ({o_meas_stb, o_half_period} !== hx) begin
            n_fail++;
            $display("FAIL period_edge%0d: got stb=%b hp=%0d, want stb=%b hp=%0d",
                     i, o_meas_stb, o_half_period, hx[CNT_WIDTH], hx[CNT_WIDTH-1:0]);
         end
         if (i > 1) begin
            hp_q.push_back({1'b0, 16'd250});
            @(negedge clk);
            hx = hp_q.pop_front();
            n_checks++;
            if ({o_meas_stb, o_half_period} !== hx) begin
               n_fail++;
               $display("FAIL period_pulse%0d: got stb=%b hp=%0d, want stb=%b hp=%0d",
                        i, o_meas_stb, o_half_period, hx[CNT_WIDTH], hx[CNT_WIDTH-1:0]);
            end
         end
      end
   endtask
`endif

   initial begin
      #(2 * CLK_HALF * 150000);
      $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_lock_100hz();
      test_switch_1hz();
      test_timeout_10hz();
      test_tolerance_edge();
      test_reset_midop();
`ifdef PERIOD_OUT_EN
      test_period_out();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
